// File: rtl/pwm_demod_pkg.sv
// pwm_demod_pkg: shared FSM state and pulse symbol encodings for the PWM frame demodulator.
package pwm_demod_pkg;
  typedef enum logic [1:0] {HUNT, RX, WAIT_TX, SEND} state_t;
  typedef enum logic [1:0] {SYM_NONE, SYM_0, SYM_1, SYM_DELIM} sym_t;
endpackage

// File: rtl/pulse_width_classifier.sv
// pulse_width_classifier: synchronises insig, prescales to ticks, times high pulses and classifies them.
module pulse_width_classifier
  import pwm_demod_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int LAT_W    = 10,
  parameter int B0_MIN   = 417,
  parameter int B0_MAX   = 431,
  parameter int B1_MIN   = 489,
  parameter int B1_MAX   = 503
) (
  input  logic clock,
  input  logic reset,
  input  logic insig,
  input  logic clr,
  output logic tick,
  output logic high,
  output logic sym_valid,
  output sym_t sym
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic meta;
  logic [PW-1:0] pre;
  logic [LAT_W-1:0] lat;
  assign tick = pre == PW'(PRESCALE - 1);
  assign sym_valid = tick && !clr && !high;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      high <= 1'b0;
      pre  <= '0;
      lat  <= '0;
    end else begin
      meta <= insig;
      high <= meta;
      pre  <= tick ? '0 : pre + 1'b1;
      if (clr) lat <= '0;
      else if (tick) lat <= high ? (&lat ? lat : lat + 1'b1) : '0;
    end
  end
  // lat is still the finished run length on the first low tick
  always_comb
    sym = lat == '0 ? SYM_NONE :
          (lat >= LAT_W'(B0_MIN) && lat <= LAT_W'(B0_MAX)) ? SYM_0 :
          (lat >= LAT_W'(B1_MIN) && lat <= LAT_W'(B1_MAX)) ? SYM_1 : SYM_DELIM;
endmodule

// File: rtl/pwm_frame_demodulator.sv
// pwm_frame_demodulator: assembles classified pulses into sync+payload frames, hands them off
// over valid/ready and opens a delayed, timed transmit window.
module pwm_frame_demodulator
  import pwm_demod_pkg::*;
#(
  parameter int PRESCALE    = 50,
  parameter int LAT_W       = 10,
  parameter int B0_MIN      = 417,
  parameter int B0_MAX      = 431,
  parameter int B1_MIN      = 489,
  parameter int B1_MAX      = 503,
  parameter int SYNC_W      = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1010,
  parameter int FRAME_BITS  = 16,
  parameter int GAP_TIMEOUT = 1000,
  parameter int TX_DELAY    = 3000,
  parameter int TX_HOLD     = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  insig,
  input  logic                  enable,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  sending,
  output logic                  busy,
  output logic                  err_pulse,
  output logic [7:0]            err_count
);
  localparam int TOTAL = SYNC_W + FRAME_BITS;
  localparam int LW = $clog2(TOTAL + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int TW = $clog2((TX_DELAY > TX_HOLD ? TX_DELAY : TX_HOLD) + 1);
  state_t state, state_n;
  logic [TOTAL-1:0] shreg, shreg_n;
  logic [LW-1:0] len, len_n;
  logic [GW-1:0] gap, gap_n;
  logic [TW-1:0] tx, tx_n;
  logic sending_n, err, accept, ovr, measure, tick, high, sym_valid;
  sym_t sym;
  assign measure = enable && (state == HUNT || state == RX);
  assign busy = state == WAIT_TX || state == SEND;
  assign ovr = accept && frame_valid && !frame_ready;
  pulse_width_classifier #(
    .PRESCALE(PRESCALE), .LAT_W(LAT_W), .B0_MIN(B0_MIN), .B0_MAX(B0_MAX),
    .B1_MIN(B1_MIN), .B1_MAX(B1_MAX)
  ) u_cls (
    .clock(clock), .reset(reset), .insig(insig), .clr(!measure),
    .tick(tick), .high(high), .sym_valid(sym_valid), .sym(sym)
  );
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    len_n = len;
    gap_n = gap;
    tx_n = tx;
    sending_n = sending;
    err = 1'b0;
    accept = 1'b0;
    if (!enable) begin
      state_n = HUNT;
      {shreg_n, len_n, gap_n, tx_n} = '0;
      sending_n = 1'b0;
    end else if (tick && measure) begin
      if (high) gap_n = '0;
      else if (sym_valid && sym == SYM_NONE) begin
        gap_n = gap + 1'b1;
        if (gap_n == GW'(GAP_TIMEOUT)) {shreg_n, len_n, gap_n} = '0;
      end else if (sym_valid && sym != SYM_DELIM) begin
        gap_n = '0;
        err = len == LW'(TOTAL);
        shreg_n = err ? '0 : {shreg[TOTAL-2:0], sym == SYM_1};
        len_n = err ? '0 : len + 1'b1;
      end else if (sym_valid) begin
        accept = len == LW'(TOTAL) && shreg[TOTAL-1 -: SYNC_W] == SYNC_PATTERN;
        err = !accept && len != '0;
        {shreg_n, len_n} = '0;
        if (accept) gap_n = '0;
      end
      state_n = accept ? WAIT_TX : len_n == '0 ? HUNT : RX;
    end else if (tick) begin
      // WAIT_TX and SEND share one tick counter, reloaded at each phase change
      tx_n = tx + 1'b1;
      if (tx_n == TW'(state == WAIT_TX ? TX_DELAY : TX_HOLD)) begin
        tx_n = '0;
        sending_n = state == WAIT_TX;
        state_n = state == WAIT_TX ? SEND : HUNT;
        {len_n, gap_n} = '0;
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= HUNT;
      {shreg, len, gap, tx} <= '0;
      sending <= 1'b0;
      frame_data <= '0;
      frame_valid <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      len <= len_n;
      gap <= gap_n;
      tx <= tx_n;
      sending <= sending_n;
      err_pulse <= err || ovr;
      if ((err || ovr) && err_count != 8'hff) err_count <= err_count + 1'b1;
      if (accept && !ovr) begin
        frame_data <= shreg[FRAME_BITS-1:0];
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) frame_valid <= 1'b0;
    end
  end
endmodule
